// File: rtl/pe_dot_seq.sv
// Dot-product sequencer: feeds operand triples into an external 3-lane PE, tags in-flight beats, accumulates results.
// Optional ACC_SAT_EN: saturating accumulation; default build wraps in two's complement.
module pe_dot_seq #(
    parameter int A      = 8,
    parameter int B      = 8,
    parameter int PE_O   = A + B + 2,
    parameter int PE_LAT = 4,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_busy,
    input  logic               i_op_valid,
    output logic               o_op_ready,
    input  logic [3*A-1:0]     i_op_a,
    input  logic [3*B-1:0]     i_op_b,
    output logic [3*A-1:0]     o_pe_mul_a,
    output logic [3*B-1:0]     o_pe_mul_b,
    input  logic [PE_O-1:0]    i_pe_out,
    output logic               o_res_valid,
    output logic [ACC_W-1:0]   o_res,
    input  logic               i_res_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W:0]   beats_q, beats_d;
    logic [LEN_W-1:0] tail_q, tail_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PE_LAT:0]  tag_q, tag_d;
    logic [3*A-1:0]   mul_a_q, mul_a_d;
    logic [3*B-1:0]   mul_b_q, mul_b_d;

    logic [LEN_W:0]   len_p2;
    logic [LEN_W:0]   beats_init;
    logic [LEN_W-1:0] tail_init;
    logic             accept;
    logic             last_beat;
    logic             lane_en;
    logic [3*A-1:0]   masked_a;
    logic [3*B-1:0]   masked_b;

    logic signed [ACC_W-1:0] pe_ext;
    logic signed [ACC_W:0]   sum_w;
    logic [ACC_W-1:0]        acc_next;

    assign len_p2     = {1'b0, i_len} + (LEN_W+1)'(2);
    assign beats_init = len_p2 / (LEN_W+1)'(3);
    assign tail_init  = i_len % LEN_W'(3);
    assign last_beat  = (beats_q == (LEN_W+1)'(1));

    // On the tail beat only the first tail_q lanes carry data (tail_q==0 means a full beat).
    always_comb begin
        masked_a = '0;
        masked_b = '0;
        lane_en  = 1'b0;
        for (int unsigned l = 0; l < 3; l++) begin
            lane_en = !last_beat || (tail_q == '0) || (LEN_W'(l) < tail_q);
            if (lane_en) begin
                masked_a[l*A +: A] = i_op_a[l*A +: A];
                masked_b[l*B +: B] = i_op_b[l*B +: B];
            end
        end
    end

    assign pe_ext = ACC_W'($signed(i_pe_out));
    assign sum_w  = {acc_q[ACC_W-1], acc_q} + {pe_ext[ACC_W-1], pe_ext};

`ifdef ACC_SAT_EN
    always_comb begin
        if (sum_w[ACC_W] != sum_w[ACC_W-1])
            acc_next = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_next = sum_w[ACC_W-1:0];
    end
`else
    assign acc_next = sum_w[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        tail_d  = tail_q;
        acc_d   = acc_q;
        mul_a_d = '0;
        mul_b_d = '0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    beats_d = beats_init;
                    tail_d  = tail_init;
                    acc_d   = '0;
                    state_d = (i_len == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                accept = i_op_valid;
                if (accept) begin
                    mul_a_d = masked_a;
                    mul_b_d = masked_b;
                    beats_d = beats_q - (LEN_W+1)'(1);
                    if (last_beat)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tag_q == '0)
                    state_d = S_DONE;
            end
            default: begin
                if (i_res_ready)
                    state_d = S_IDLE;
            end
        endcase
        if (tag_q[PE_LAT] && (state_q == S_FEED || state_q == S_DRAIN))
            acc_d = acc_next;
        tag_d = {tag_q[PE_LAT-1:0], accept};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            beats_q <= '0;
            tail_q  <= '0;
            acc_q   <= '0;
            tag_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            tail_q  <= tail_d;
            acc_q   <= acc_d;
            tag_q   <= tag_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_op_ready  = (state_q == S_FEED);
    assign o_res_valid = (state_q == S_DONE);
    assign o_res       = acc_q;
    assign o_pe_mul_a  = mul_a_q;
    assign o_pe_mul_b  = mul_b_q;

endmodule

// File: tb/tb_pe_dot_seq.sv
// Directed bench for pe_dot_seq (ACC_W=20) with a behavioural 4-cycle 3-lane PE model.
module tb_pe_dot_seq;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_len;
    logic        o_busy;
    logic        i_op_valid;
    logic        o_op_ready;
    logic [23:0] i_op_a;
    logic [23:0] i_op_b;
    logic [23:0] o_pe_mul_a;
    logic [23:0] o_pe_mul_b;
    logic [17:0] pe_out;
    logic        o_res_valid;
    logic [19:0] o_res;
    logic        i_res_ready;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [23:0] va [0:15];
    logic [23:0] vb [0:15];

    always #5 clk = ~clk;

    pe_dot_seq #(.A(8), .B(8), .PE_O(18), .PE_LAT(4), .LEN_W(8), .ACC_W(20)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
        .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_op_a(i_op_a), .i_op_b(i_op_b),
        .o_pe_mul_a(o_pe_mul_a), .o_pe_mul_b(o_pe_mul_b), .i_pe_out(pe_out),
        .o_res_valid(o_res_valid), .o_res(o_res), .i_res_ready(i_res_ready)
    );

    // PE model: signed 3-lane dot product, visible 4 cycles after the operands change.
    logic signed [17:0] pe_sum;
    logic signed [17:0] pe_pipe [0:3];
    always_comb begin
        pe_sum = '0;
        for (int l = 0; l < 3; l++)
            pe_sum = pe_sum + 18'($signed(o_pe_mul_a[l*8 +: 8]) * $signed(o_pe_mul_b[l*8 +: 8]));
    end
    always @(posedge clk) begin
        pe_pipe[0] <= pe_sum;
        for (int s = 1; s < 4; s++) pe_pipe[s] <= pe_pipe[s-1];
    end
    assign pe_out = pe_pipe[3];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_job(input int len, input bit toggle, input int hold, input bit noise,
                          output logic [19:0] res, output int lat, output bit stable,
                          output bit saw_ready, output logic [23:0] last_mul_a,
                          output bit dropped, output bit timeout);
        int nb;
        int bi;
        int guard;
        int acc_cyc;
        bit ph;
        nb = (len + 2) / 3; bi = 0; guard = 0; ph = 1'b1;
        timeout = 0; stable = 1; saw_ready = 0; dropped = 0; last_mul_a = '0; lat = 0;
        i_res_ready = (hold == 0);
        i_len = 8'(len);
        i_start = 1'b1;
        step();
        if (noise) begin i_start = 1'b1; i_len = 8'd9; end
        else i_start = 1'b0;
        acc_cyc = cyc;
        while (bi < nb && guard < 300) begin
            i_op_valid = toggle ? ph : 1'b1;
            ph = !ph;
            i_op_a = va[bi];
            i_op_b = vb[bi];
            if (o_op_ready) saw_ready = 1;
            if (o_op_ready && i_op_valid) begin
                step();
                acc_cyc = cyc;
                last_mul_a = o_pe_mul_a;
                bi++;
            end else begin
                step();
            end
            guard++;
        end
        i_op_valid = 1'b0; i_op_a = '0; i_op_b = '0;
        while (!o_res_valid && guard < 300) begin
            if (o_op_ready) saw_ready = 1;
            step();
            guard++;
        end
        if (!o_res_valid) timeout = 1;
        lat = cyc - acc_cyc;
        res = o_res;
        i_start = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            if (!o_res_valid || o_res !== res) stable = 0;
        end
        i_res_ready = 1'b1;
        step();
        dropped = !o_res_valid && !o_busy;
        i_res_ready = 1'b0;
    endtask

    logic [19:0] res;
    int          lat;
    bit          stable, saw_ready, dropped, timeout;
    logic [23:0] lm;

    task automatic test_reset();
        i_reset = 1'b1;
        step(); step();
        total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", o_busy); else passed++;
        total++; if (o_op_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", o_op_ready); else passed++;
        total++; if (o_res_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", o_res_valid); else passed++;
        total++; if (o_res !== 20'h0) $display("FAIL reset_res got=%h exp=0", o_res); else passed++;
        total++; if (o_pe_mul_a !== 24'h0 || o_pe_mul_b !== 24'h0)
            $display("FAIL reset_mul got=%h/%h exp=0/0", o_pe_mul_a, o_pe_mul_b); else passed++;
        #2 i_reset = 1'b0;
        step(); step();
    endtask

    task automatic test_basic();
        va[0] = 24'h030201; vb[0] = 24'h060504;
        do_job(3, 0, 0, 0, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== 20'd32) $display("FAIL basic_res got=%0d exp=32 timeout=%0b", res, timeout); else passed++;
        total++; if (lat !== 6) $display("FAIL basic_latency got=%0d exp=6", lat); else passed++;
        total++; if (!dropped) $display("FAIL basic_valid_drop got=%0b exp=1", dropped); else passed++;
    endtask

    task automatic test_tail_mask();
        va[0] = 24'h030201; vb[0] = 24'h010101;
        va[1] = 24'h630504; vb[1] = 24'h010101;
        do_job(5, 0, 0, 0, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== 20'd15) $display("FAIL tail_res got=%0d exp=15", res); else passed++;
        total++; if (lm !== 24'h000504) $display("FAIL tail_mask_mul_a got=%h exp=000504", lm); else passed++;
    endtask

    task automatic test_signed_and_zero();
        va[0] = 24'hFEFEFE; vb[0] = 24'h030303;
        do_job(3, 0, 0, 0, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== 20'hFFFEE) $display("FAIL signed_res got=%h exp=FFFEE", res); else passed++;
        do_job(0, 0, 0, 0, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== 20'h0) $display("FAIL len0_res got=%h exp=0", res); else passed++;
        total++; if (saw_ready) $display("FAIL len0_no_handshake got=%0b exp=0", saw_ready); else passed++;
        total++; if (!dropped) $display("FAIL len0_valid_drop got=%0b exp=1", dropped); else passed++;
    endtask

    task automatic test_backpressure();
        va[0] = 24'h030201; vb[0] = 24'h010101;
        va[1] = 24'h060504; vb[1] = 24'h020202;
        do_job(6, 1, 5, 1, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== 20'd36) $display("FAIL bp_res got=%0d exp=36", res); else passed++;
        total++; if (!stable) $display("FAIL bp_res_stable got=%0b exp=1", stable); else passed++;
        total++; if (lat !== 6) $display("FAIL bp_latency got=%0d exp=6", lat); else passed++;
        total++; if (!dropped) $display("FAIL bp_no_restart got=%0b exp=1", dropped); else passed++;
    endtask

    task automatic test_mid_reset();
        i_len = 8'd3; i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_op_valid = 1'b1; i_op_a = 24'h050505; i_op_b = 24'h070707;
        step();
        i_op_valid = 1'b0; i_op_a = '0; i_op_b = '0;
        #2 i_reset = 1'b1;
        #1;
        total++; if (o_busy !== 1'b0 || o_op_ready !== 1'b0 || o_res_valid !== 1'b0)
            $display("FAIL midreset_ctrl got=%0b%0b%0b exp=000", o_busy, o_op_ready, o_res_valid); else passed++;
        total++; if (o_res !== 20'h0 || o_pe_mul_a !== 24'h0 || o_pe_mul_b !== 24'h0)
            $display("FAIL midreset_data got=%h/%h/%h exp=0/0/0", o_res, o_pe_mul_a, o_pe_mul_b); else passed++;
        #2 i_reset = 1'b0;
        step();
        va[0] = 24'h010101; vb[0] = 24'h010101;
        do_job(3, 0, 0, 0, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== 20'd3) $display("FAIL midreset_next_res got=%0d exp=3", res); else passed++;
    endtask

    task automatic test_saturation();
        logic [19:0] exp_v;
        for (int i = 0; i < 11; i++) begin va[i] = 24'h808080; vb[i] = 24'h808080; end
`ifdef ACC_SAT_EN
        exp_v = 20'h7FFFF;
`else
        exp_v = 20'h84000;
`endif
        do_job(33, 0, 0, 0, res, lat, stable, saw_ready, lm, dropped, timeout);
        total++; if (timeout || res !== exp_v) $display("FAIL overflow_res got=%h exp=%h", res, exp_v); else passed++;
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_op_valid = 1'b0;
        i_op_a = '0; i_op_b = '0; i_res_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin va[i] = '0; vb[i] = '0; end
        test_reset();
        test_basic();
        test_tail_mask();
        test_signed_and_zero();
        test_backpressure();
        test_mid_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pe_dot_seq.md
Name: pe_dot_seq

Overview:
Sequencer wrapping one 3-lane `pe` (three A×B signed multipliers plus an adder tree, registered output).
- Accepts a dot-product job of `i_len` elements.
- Streams operand triples from an upstream source into the PE and masks unused lanes on the tail beat.
- Tracks in-flight beats through the PE pipeline, accumulates the PE outputs, and returns one result over a valid/ready handshake.
- Sits between the operand buffers and the result writeback in the PE array.

Parameters:
A, 8, operand-a lane width (signed)
B, 8, operand-b lane width (signed)
PE_O, A+B+2, PE output width
PE_LAT, 4, cycles from o_pe_mul_a/b change to i_pe_out reflecting it
LEN_W, 8, job length field width
ACC_W, 32, accumulator/result width (must be ≥ PE_O)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-high
i_start  in  1  job start pulse; sampled only in IDLE
i_len  in  LEN_W  element count, latched on accepted start
o_busy  out  1  high in every state except IDLE
i_op_valid  in  1  operand triple valid
o_op_ready  out  1  controller accepts triple
i_op_a  in  3*A  lanes a0..a2, a0 in LSBs
i_op_b  in  3*B  lanes b0..b2, b0 in LSBs
o_pe_mul_a  out  3*A  registered PE operand a
o_pe_mul_b  out  3*B  registered PE operand b
i_pe_out  in  PE_O  PE result (signed)
o_res_valid  out  1  result valid
o_res  out  ACC_W  signed dot-product result
i_res_ready  in  1  result consumer ready

Behaviour:
- Reset (async, i_reset=1): state=IDLE; o_busy, o_op_ready, o_res_valid = 0; o_res, o_pe_mul_a, o_pe_mul_b, accumulator, beat counter and tag pipe = 0. Reset mid-job abandons the job; no result is produced.
- Beat count: beats = ceil(len/3). Tail lanes = len mod 3 (0 means all 3 lanes are valid).
- States:
  - IDLE: i_start=1 latches i_len, clears the accumulator, and loads the beat counter. len=0 → DONE with o_res=0. Otherwise → FEED.
  - FEED: o_op_ready=1. On i_op_valid && o_op_ready:
    - Register the operands into o_pe_mul_a/b.
    - On the last beat, force lanes ≥ tail count to 0 in both a and b.
    - Push tag=1 into the PE_LAT+1-deep tag shift register.
    - Decrement the beat counter.
    - On cycles with no accept, o_pe_mul_a/b = 0 and tag=0.
    - After the last beat is accepted → DRAIN.
  - DRAIN: o_op_ready=0 and o_pe_mul_a/b = 0. Leave for DONE when the tag pipe is empty.
  - DONE: o_res_valid=1, o_res = accumulator, both held stable until i_res_ready=1. Then o_res_valid drops next cycle → IDLE.
- Accumulation: every cycle the tag pipe output is 1, acc ← acc + sign_extend(i_pe_out, ACC_W). Default arithmetic is two's-complement wrap. Accumulation is active in FEED and DRAIN.
- Latency: accepted beat → contribution in acc after PE_LAT+1 cycles. Last accept → o_res_valid after PE_LAT+2 cycles.
- i_start is ignored while o_busy=1. i_op_valid is ignored outside FEED.
- Back-to-back: i_start is accepted in the first IDLE cycle after DONE.
- o_op_ready is combinational from state only (no dependence on i_op_valid).

Optional Feature:
ACC_SAT_EN
- Defined: each accumulate saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Once saturated, later addends can still move acc back in range (per-add saturation, not sticky).
- Undefined: two's-complement wrap-around.

Test Plan:
- len=3, a={1,2,3}, b={4,5,6}, i_res_ready=1 → one o_res_valid pulse with o_res=32, PE_LAT+2 cycles after accept.
- len=5, beats a={1,2,3},{4,5,99}, b all 1 (lane2 of beat 2 = 99) → o_res=15 (tail lane masked; check o_pe_mul_a lane2=0 on beat 2).
- Signed: len=3, a={−2,−2,−2}, b={3,3,3} → o_res=−18; also len=0 → o_res=0 with no operand handshake.
- Backpressure: i_op_valid toggled 1/0 each cycle over len=6, i_res_ready held 0 for 5 cycles → correct sum, o_res stable while waiting, i_start during job ignored.
- Reset: assert i_reset in FEED after 1 of 3 beats → all outputs 0 immediately. Next job len=3, a={1,1,1}, b={1,1,1} → o_res=3 (no stale acc/tags).
- ACC_W=20, len=33, all a=b=−128 (49152/beat, 11 beats = 540672) → with ACC_SAT_EN o_res=524287; without it o_res=−507904.
